// File: rtl/uart_pkg.sv
// Shared UART line levels, frame width and transmit FSM state encoding.
// Pure constants/types: no latency, no flow control.
package uart_pkg;

  localparam int   UART_DATA_BITS = 8;
  localparam logic UART_START_LVL = 1'b0;
  localparam logic UART_STOP_LVL  = 1'b1;
  localparam logic UART_IDLE_LVL  = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO, first-word-fall-through dout; push visible in count one edge later.
// Push while full and pop while empty are ignored; a same-cycle pop never frees room for a push.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_do_push = push && !full;
  assign w_do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: bytes queue in a FIFO, tx_out falls one edge after the FIFO holds a byte.
// wr_ready drops only when the FIFO is full; writes attempted while full are dropped and flagged sticky.
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 16,
  parameter  int FIFO_DEPTH   = 8,
  localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  input  logic [7:0]       wr_data,
  output logic             wr_ready,
  output logic             tx_out,
  output logic             busy,
  output logic             tx_done,
  output logic [CNT_W-1:0] fifo_count,
  output logic             drop_err
);

  localparam int             BCW      = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BCW-1:0] LAST_CNT = BCW'(CLKS_PER_BIT - 1);
  localparam logic [BCW-1:0] DONE_CNT = BCW'(CLKS_PER_BIT - 2);
  localparam logic [2:0]     LAST_IDX = 3'(UART_DATA_BITS - 1);

  tx_state_t        r_state;
  logic [BCW-1:0]   r_bit_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic             r_tx_out;
  logic             r_tx_done;
  logic             r_drop_err;

  logic             w_push;
  logic             w_pop;
  logic             w_full;
  logic             w_empty;
  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count;

  assign w_push = wr_valid && !w_full;
  // Pop only where the FSM loads a new frame: from IDLE, or at the final stop cycle.
  assign w_pop  = !w_empty &&
                  ((r_state == IDLE) || ((r_state == STOP) && (r_bit_cnt == LAST_CNT)));

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (wr_data),
    .dout  (w_head),
    .count (w_count),
    .full  (w_full),
    .empty (w_empty)
  );

  assign wr_ready   = !w_full;
  assign fifo_count = w_count;
  assign tx_out     = r_tx_out;
  assign busy       = (r_state != IDLE);
  assign tx_done    = r_tx_done;
  assign drop_err   = r_drop_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_err <= 1'b0;
    end else if (wr_valid && w_full) begin
      r_drop_err <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx_out  <= UART_IDLE_LVL;
      r_tx_done <= 1'b0;
    end else begin
      r_tx_done <= 1'b0;
      case (r_state)
        IDLE: begin
          r_tx_out  <= UART_IDLE_LVL;
          r_bit_cnt <= '0;
          if (w_pop) begin
            r_shift  <= w_head;
            r_tx_out <= UART_START_LVL;
            r_state  <= START;
          end
        end
        START: begin
          if (r_bit_cnt == LAST_CNT) begin
            r_bit_cnt <= '0;
            r_bit_idx <= '0;
            r_tx_out  <= r_shift[0];
            r_shift   <= {1'b0, r_shift[7:1]};
            r_state   <= DATA;
          end else begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
          end
        end
        DATA: begin
          if (r_bit_cnt == LAST_CNT) begin
            r_bit_cnt <= '0;
            if (r_bit_idx == LAST_IDX) begin
              r_tx_out <= UART_STOP_LVL;
              r_state  <= STOP;
            end else begin
              r_bit_idx <= r_bit_idx + 3'd1;
              r_tx_out  <= r_shift[0];
              r_shift   <= {1'b0, r_shift[7:1]};
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
          end
        end
        STOP: begin
          // Registered one cycle early so the pulse coincides with the last stop cycle.
          if (r_bit_cnt == DONE_CNT) r_tx_done <= 1'b1;
          if (r_bit_cnt == LAST_CNT) begin
            r_bit_cnt <= '0;
            if (w_pop) begin
              r_shift  <= w_head;
              r_tx_out <= UART_START_LVL;
              r_state  <= START;
            end else begin
              r_tx_out <= UART_IDLE_LVL;
              r_state  <= IDLE;
            end
          end else begin
            r_bit_cnt <= r_bit_cnt + BCW'(1);
          end
        end
        default: begin
          r_tx_out <= UART_IDLE_LVL;
          r_state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Directed bench for uart_tx_buffered at CLKS_PER_BIT=4, FIFO_DEPTH=8.
// A line decoder on tx_out collects received bytes and frame start cycles.
module tb_uart_tx_buffered;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [7:0] wr_data;
  logic       wr_ready;
  logic       tx_out;
  logic       busy;
  logic       tx_done;
  logic [3:0] fifo_count;
  logic       drop_err;

  uart_tx_buffered #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .tx_out     (tx_out),
    .busy       (busy),
    .tx_done    (tx_done),
    .fifo_count (fifo_count),
    .drop_err   (drop_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Serial line decoder: start seen at position 0, mid-bit samples at CPB*b+2.
  logic [7:0] rx_q[$];
  int         start_q[$];
  int         mon_pos   = -1;
  logic [7:0] mon_sh    = 8'h00;
  int         frame_err = 0;
  int         done_n    = 0;

  always @(negedge clk) begin
    if (rst) begin
      mon_pos = -1;
    end else begin
      if (tx_done === 1'b1) done_n++;
      if (mon_pos < 0) begin
        if (tx_out === 1'b0) begin
          mon_pos = 0;
          start_q.push_back(cyc);
        end
      end else begin
        mon_pos++;
        if (mon_pos == 2 && tx_out !== 1'b0) frame_err++;
        for (int b = 1; b <= 8; b++)
          if (mon_pos == CPB * b + 2) mon_sh[b-1] = tx_out;
        if (mon_pos == CPB * 9 + 2) begin
          if (tx_out === 1'b1) rx_q.push_back(mon_sh);
          else frame_err++;
          mon_pos = -1;
        end
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  function automatic int start_at(input int i);
    if (i < start_q.size()) return start_q[i];
    return -1000;
  endfunction

  task automatic wait_cyc(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  int         k;
  int         bad;
  int         base_rx;
  int         base_st;
  int         base_done;
  int         b;
  logic [9:0] frame;

  initial begin
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_data  = 8'h00;
    #2;
    chk("rst_tx_out",   32'(tx_out),     32'd1);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_tx_done",  32'(tx_done),    32'd0);
    chk("rst_count",    32'(fifo_count), 32'd0);
    chk("rst_drop_err", 32'(drop_err),   32'd0);
    chk("rst_wr_ready", 32'(wr_ready),   32'd1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle with no writes
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0 || wr_ready !== 1'b1 || fifo_count !== 4'd0) bad++;
    end
    chk("idle_50_cycles", 32'(bad), 32'd0);

    // Single byte 0xA5
    base_rx = rx_q.size(); base_done = done_n;
    wr_valid = 1'b1; wr_data = 8'hA5;
    @(negedge clk);
    wr_valid = 1'b0; k = cyc;
    chk("a5_no_bypass_tx", 32'(tx_out),     32'd1);
    chk("a5_count_after",  32'(fifo_count), 32'd1);
    chk("a5_busy_before",  32'(busy),       32'd0);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int c = k + 1; c <= k + 42; c++) begin
      @(negedge clk);
      b = (c - k - 1) / CPB;
      chk("a5_tx_bit", 32'(tx_out),  (b < 10) ? 32'(frame[b]) : 32'd1);
      chk("a5_tx_done", 32'(tx_done), (c == k + 40) ? 32'd1 : 32'd0);
      chk("a5_busy",    32'(busy),    (c <= k + 40) ? 32'd1 : 32'd0);
    end
    chk("a5_done_pulses", 32'(done_n - base_done), 32'd1);
    chk("a5_rx_count",    32'(rx_q.size() - base_rx), 32'd1);
    chk("a5_rx_byte",     32'(rx_at(base_rx)), 32'hA5);

    // Back-to-back 0x00, 0xFF, 0x3C
    base_rx = rx_q.size(); base_st = start_q.size(); base_done = done_n;
    wr_valid = 1'b1; wr_data = 8'h00;
    @(negedge clk); k = cyc; wr_data = 8'hFF;
    @(negedge clk); wr_data = 8'h3C;
    @(negedge clk); wr_valid = 1'b0;
    chk("b2b_count", 32'(fifo_count), 32'd2);
    for (int c = k + 3; c <= k + 123; c++) begin
      @(negedge clk);
      chk("b2b_busy", 32'(busy), (c <= k + 120) ? 32'd1 : 32'd0);
      chk("b2b_tx_done", 32'(tx_done),
          (c == k + 40 || c == k + 80 || c == k + 120) ? 32'd1 : 32'd0);
    end
    chk("b2b_done_pulses", 32'(done_n - base_done), 32'd3);
    chk("b2b_start0",  32'(start_at(base_st)), 32'(k + 1));
    chk("b2b_start1",  32'(start_at(base_st + 1)), 32'(k + 41));
    chk("b2b_start2",  32'(start_at(base_st + 2)), 32'(k + 81));
    chk("b2b_rx_count", 32'(rx_q.size() - base_rx), 32'd3);
    chk("b2b_rx0", 32'(rx_at(base_rx)),     32'h00);
    chk("b2b_rx1", 32'(rx_at(base_rx + 1)), 32'hFF);
    chk("b2b_rx2", 32'(rx_at(base_rx + 2)), 32'h3C);

    // Overflow: 10 writes, 9 accepted, 10th dropped
    base_rx = rx_q.size();
    wr_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 8'h30 + 8'(i);
      if (i == 9) begin
        chk("ovf_count_full",  32'(fifo_count), 32'd8);
        chk("ovf_ready_low",   32'(wr_ready),   32'd0);
        chk("ovf_drop_before", 32'(drop_err),   32'd0);
      end
      @(negedge clk);
    end
    wr_valid = 1'b0;
    chk("ovf_drop_set",    32'(drop_err),   32'd1);
    chk("ovf_count_after", 32'(fifo_count), 32'd8);
    repeat (9 * 40 + 10) @(negedge clk);
    chk("ovf_rx_count", 32'(rx_q.size() - base_rx), 32'd9);
    for (int i = 0; i < 9; i++)
      chk("ovf_rx_byte", 32'(rx_at(base_rx + i)), 32'h30 + 32'(i));
    chk("ovf_drop_sticky", 32'(drop_err),   32'd1);
    chk("ovf_drained",     32'(fifo_count), 32'd0);
    chk("ovf_ready_back",  32'(wr_ready),   32'd1);

    // Reset during data bit 3 of 0x55 with 0x66 still queued
    wr_valid = 1'b1; wr_data = 8'h55;
    @(negedge clk); k = cyc; wr_data = 8'h66;
    @(negedge clk); wr_valid = 1'b0;
    wait_cyc(k + 18);
    chk("mid_tx_before",    32'(tx_out),     32'd0);
    chk("mid_busy_before",  32'(busy),       32'd1);
    chk("mid_count_before", 32'(fifo_count), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("mid_tx_async",    32'(tx_out),     32'd1);
    chk("mid_count_async", 32'(fifo_count), 32'd0);
    chk("mid_busy_async",  32'(busy),       32'd0);
    chk("mid_ready_async", 32'(wr_ready),   32'd1);
    chk("mid_drop_clear",  32'(drop_err),   32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    base_rx = rx_q.size(); base_done = done_n;
    bad = 0;
    repeat (60) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    chk("mid_quiet_after", 32'(bad), 32'd0);
    chk("mid_no_rx",       32'(rx_q.size() - base_rx), 32'd0);
    chk("mid_no_done",     32'(done_n - base_done), 32'd0);

    // Loopback stream 0x12, 0x80, 0xFE
    base_rx = rx_q.size();
    wr_valid = 1'b1; wr_data = 8'h12;
    @(negedge clk); wr_data = 8'h80;
    @(negedge clk); wr_data = 8'hFE;
    @(negedge clk); wr_valid = 1'b0;
    repeat (3 * 40 + 10) @(negedge clk);
    chk("lb_rx_count", 32'(rx_q.size() - base_rx), 32'd3);
    chk("lb_rx0", 32'(rx_at(base_rx)),     32'h12);
    chk("lb_rx1", 32'(rx_at(base_rx + 1)), 32'h80);
    chk("lb_rx2", 32'(rx_at(base_rx + 2)), 32'hFE);
    chk("frame_errors", 32'(frame_err), 32'd0);
    chk("final_idle_tx", 32'(tx_out), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
Name: uart_tx_buffered

Overview:
- Buffered UART transmitter: accepts bytes over a valid/ready write port into an internal FIFO and serialises them on tx_out as 8N1 frames (1 start, 8 data LSB-first, 1 stop).
- Lets upstream logic queue bursts without waiting for each frame to finish.
- Counterpart of the existing receive path; loops back into uart_rx for system test.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit (>=2).
- FIFO_DEPTH, 8, byte entries; power of 2, >=2.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of fifo_count (derived, not overridden).

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- wr_valid  in  1  write request.
- wr_data  in  8  byte to queue.
- wr_ready  out  1  FIFO not full (combinational from registered count).
- tx_out  out  1  serial line, registered, idle high.
- busy  out  1  frame in progress (state != IDLE).
- tx_done  out  1  one-cycle pulse at end of each stop bit.
- fifo_count  out  CNT_W  entries currently queued (excludes the byte being shifted).
- drop_err  out  1  sticky: write attempted while full.

Behaviour:
- Reset (async, immediate, including mid-frame):
  - tx_out=1, busy=0, tx_done=0, fifo_count=0, drop_err=0, wr_ready=1.
  - FIFO pointers cleared, state=IDLE; any partial frame is abandoned, not resumed.
- Write:
  - Accepted on an edge where wr_valid && wr_ready; fifo_count increments that edge.
  - No bypass: an empty FIFO still needs one edge to register the byte.
  - wr_valid && !wr_ready: data discarded, drop_err<=1 (held until reset), count unchanged.
- Simultaneous accept and pop: count unchanged, both pointers advance.
- wr_ready = (fifo_count != FIFO_DEPTH). A pop in the same cycle does not make room for a write.
- FSM states IDLE, START, DATA, STOP; bit_cnt counts 0..CLKS_PER_BIT-1; bit_idx counts 0..7.
  - IDLE: tx_out=1. If fifo_count!=0 on an edge, pop the head into the shift register, tx_out<=0, go to START.
    - Latency: byte accepted at edge k drives tx_out low after edge k+1.
  - START: hold 0 for CLKS_PER_BIT cycles, then tx_out<=shift[0], go to DATA with bit_idx=0.
  - DATA: each bit held CLKS_PER_BIT cycles; shift right each bit. After bit 7, tx_out<=1 and go to STOP.
  - STOP: hold 1 for CLKS_PER_BIT cycles. On the last cycle, tx_done<=1 for one cycle, then:
    - if fifo_count!=0: pop, tx_out<=0, go to START (back-to-back, no idle gap);
    - else go to IDLE.
- Frame length is exactly 10*CLKS_PER_BIT cycles.
- busy=1 from the pop edge to the edge that enters IDLE.
- Counter wrap: FIFO pointers wrap modulo FIFO_DEPTH. fifo_count never exceeds FIFO_DEPTH or underflows.

Decomposition:
- Package uart_pkg:
  - constants UART_DATA_BITS=8, UART_START_LVL=1'b0, UART_STOP_LVL=1'b1, UART_IDLE_LVL=1'b1;
  - tx state enum (IDLE/START/DATA/STOP).
- Sub-module sync_fifo:
  - parameterised width/depth, async active-high reset;
  - ports push/pop/din/dout/count/full/empty, first-word-fall-through dout.
- Serialiser FSM stays in uart_tx_buffered.

Test Plan:
- Reset idle: assert rst, release, 50 cycles no writes -> tx_out=1, busy=0, wr_ready=1, fifo_count=0 throughout.
- Single byte, CLKS_PER_BIT=4: write 0xA5 at edge k -> tx_out low from edge k+1, then bits 1,0,1,0,0,1,0,1 (LSB-first) at 4 cycles each, then stop=1. tx_done pulses once at edge k+40; busy drops one edge later.
- Back-to-back: write 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous 40-cycle frames with no idle cycles between stop and next start; exactly 3 tx_done pulses.
- Full/overflow, DEPTH=8: hold wr_valid for 10 cycles with the first pop in flight -> 9 bytes accepted (1 popped + 8 queued), wr_ready=0, drop_err=1, 10th byte absent from the output stream.
- Reset mid-frame: assert rst during DATA bit 3 of 0x55 -> tx_out=1 immediately (before next edge), fifo_count=0. After release, no further frames without new writes.
- Loopback: tx_out into existing uart_rx at matching bit period, send 0x12, 0x80, 0xFE -> receiver reports the same three bytes in order.
